power_estimator: RTL and testbench

- Parametrised successor to the squared-magnitude stage in the amplitude-control path.
- Computes |z|^2 = re^2 + im^2 from a valid-qualified complex sample stream.
- Output is either per-sample (instantaneous mode) or the mean over a window of 2^LOG2_N valid samples (averaged mode), saturated to a configurable output width.
- Sits between the complex front end and the amplitude-control loop filter.

---
 rtl/power_estimator_if.sv | 36 +++
 rtl/power_estimator.sv | 144 ++++++++++++++
 tb/tb_power_estimator.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/power_estimator_if.sv
// ---------------------------------------------------------------------------
// power_estimator_if
// Bundles the complex sample stream feeding the power estimator and the
// result stream it produces.
//   real_i / imag_i : signed W_IN-bit complex sample
//   valid_i         : sample qualifier (bubbles allowed)
//   mode_i          : 0 = instantaneous, 1 = windowed average
//   clear_i         : flush the averaging window
//   res_o           : unsigned W_OUT-bit power result
//   valid_o         : one-cycle strobe qualifying res_o
//   sat_o           : result was clipped (only with valid_o)
// master = sample source / result consumer, slave = the estimator.
// ---------------------------------------------------------------------------
interface power_estimator_if #(
    parameter int W_IN  = 8,
    parameter int W_OUT = 16
);
    logic signed [W_IN-1:0] real_i;
    logic signed [W_IN-1:0] imag_i;
    logic                   valid_i;
    logic                   mode_i;
    logic                   clear_i;
    logic [W_OUT-1:0]       res_o;
    logic                   valid_o;
    logic                   sat_o;

    modport master (
        output real_i, imag_i, valid_i, mode_i, clear_i,
        input  res_o, valid_o, sat_o
    );

    modport slave (
        input  real_i, imag_i, valid_i, mode_i, clear_i,
        output res_o, valid_o, sat_o
    );
endinterface

// File: rtl/power_estimator.sv
// ---------------------------------------------------------------------------
// power_estimator
// Squared-magnitude (|z|^2 = re^2 + im^2) of a valid-qualified complex stream,
// output either per sample or as the mean over 2^LOG2_N valid samples, with
// saturation to W_OUT bits.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears every register
//   bus : power_estimator_if.slave (sample stream in, result stream out)
// Timing (edges after the sample is presented):
//   edge 1 : squares registered
//   edge 2 : sum formed; instantaneous result registered, or accumulated
//   edge 3 : averaged window result registered (window mode only)
// ---------------------------------------------------------------------------
module power_estimator #(
    parameter int W_IN   = 8,
    parameter int W_OUT  = 16,
    parameter int LOG2_N = 4
) (
    input  logic                clk,
    input  logic                rst,
    power_estimator_if.slave    bus
);
    localparam int W_SQ  = 2 * W_IN;
    localparam int W_ACC = W_SQ + LOG2_N;
    localparam int W_BIG = (W_OUT > W_SQ) ? W_OUT : W_SQ;
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    // Returns {sat, result}: clip anything above 2^W_OUT-1 to all ones.
    function automatic logic [W_OUT:0] fmt(input logic [W_SQ-1:0] v);
        logic [W_BIG-1:0] x;
        x = W_BIG'(v);
        if (x > W_BIG'({W_OUT{1'b1}}))
            return {1'b1, {W_OUT{1'b1}}};
        else
            return {1'b0, W_OUT'(x)};
    endfunction

    // Stage 1: squares. A signed square is non-negative and at most
    // 2^(2*W_IN-2), so reinterpreting it as unsigned is lossless.
    logic signed [W_SQ-1:0] w_sq_re_s;
    logic signed [W_SQ-1:0] w_sq_im_s;
    assign w_sq_re_s = bus.real_i * bus.real_i;
    assign w_sq_im_s = bus.imag_i * bus.imag_i;

    logic [W_SQ-1:0] r_sq_re;
    logic [W_SQ-1:0] r_sq_im;
    logic            r_v1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sq_re <= '0;
            r_sq_im <= '0;
            r_v1    <= 1'b0;
        end else begin
            r_sq_re <= $unsigned(w_sq_re_s);
            r_sq_im <= $unsigned(w_sq_im_s);
            r_v1    <= bus.valid_i;
        end
    end

    // Stage 2: the sum cannot wrap (max 2^(2*W_IN-1)).
    logic [W_SQ-1:0] w_sum;
    assign w_sum = r_sq_re + r_sq_im;

    logic [W_ACC-1:0]  r_acc;
    logic [LOG2_N-1:0] r_cnt;
    logic              r_mode_last;   // mode seen with the previous stage-2 strobe
    logic [W_ACC-1:0]  r_fin;         // completed window total
    logic              r_fin_v;
    logic [W_OUT-1:0]  r_res;
    logic              r_valid;
    logic              r_sat;

    // A mode change between consecutive stage-2 strobes discards the partial
    // window before the current sum is applied.
    logic              w_restart;
    logic [W_ACC-1:0]  w_acc_base;
    logic [LOG2_N-1:0] w_cnt_base;
    logic [W_ACC-1:0]  w_acc_sum;
    logic [W_SQ-1:0]   w_fin_q;
    logic [W_OUT:0]    w_fmt;

    always_comb begin
        w_restart  = (r_mode_last != bus.mode_i);
        w_acc_base = w_restart ? '0 : r_acc;
        w_cnt_base = w_restart ? '0 : r_cnt;
        w_acc_sum  = w_acc_base + W_ACC'(w_sum);
        // N sums fit in W_ACC bits, so the quotient fits in W_SQ bits.
        w_fin_q    = W_SQ'(r_fin >> LOG2_N);
        w_fmt      = r_fin_v ? fmt(w_fin_q) : fmt(w_sum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_mode_last <= 1'b0;
            r_fin       <= '0;
            r_fin_v     <= 1'b0;
            r_res       <= '0;
            r_valid     <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            r_fin_v <= 1'b0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;

            if (r_v1)
                r_mode_last <= bus.mode_i;

            // Window bookkeeping; clear drops the sum present this cycle.
            if (bus.clear_i) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_v1 && bus.mode_i) begin
                if (w_cnt_base == CNT_LAST) begin
                    r_fin   <= w_acc_sum;
                    r_fin_v <= 1'b1;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_acc <= w_acc_sum;
                    r_cnt <= w_cnt_base + 1'b1;
                end
            end else if (r_v1) begin
                r_acc <= '0;
                r_cnt <= '0;
            end

            // A finished window and an instantaneous sample can only meet on
            // the same edge right after a 1->0 mode switch; the window wins.
            if (r_fin_v || (r_v1 && !bus.mode_i)) begin
                r_res   <= w_fmt[W_OUT-1:0];
                r_sat   <= w_fmt[W_OUT];
                r_valid <= 1'b1;
            end
        end
    end

    assign bus.res_o   = r_res;
    assign bus.valid_o = r_valid;
    assign bus.sat_o   = r_sat;
endmodule

// File: tb/tb_power_estimator.sv
module tb_power_estimator;
    localparam int W_IN = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    power_estimator_if #(.W_IN(W_IN), .W_OUT(16)) bus16 ();
    power_estimator_if #(.W_IN(W_IN), .W_OUT(15)) bus15 ();

    assign bus15.real_i  = bus16.real_i;
    assign bus15.imag_i  = bus16.imag_i;
    assign bus15.valid_i = bus16.valid_i;
    assign bus15.mode_i  = bus16.mode_i;
    assign bus15.clear_i = bus16.clear_i;

    power_estimator #(.W_IN(W_IN), .W_OUT(16), .LOG2_N(4)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    power_estimator #(.W_IN(W_IN), .W_OUT(15), .LOG2_N(4)) u_dut15 (
        .clk (clk),
        .rst (rst),
        .bus (bus15.slave)
    );

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Output logs, captured away from the active edge.
    int o_res[$];
    int o_sat[$];
    int o_cyc[$];
    int o15_res[$];
    int o15_sat[$];

    always @(negedge clk) begin
        if (bus16.valid_o === 1'b1) begin
            o_res.push_back(int'(bus16.res_o));
            o_sat.push_back(int'(bus16.sat_o));
            o_cyc.push_back(cyc_n);
        end
        if (bus15.valid_o === 1'b1) begin
            o15_res.push_back(int'(bus15.res_o));
            o15_sat.push_back(int'(bus15.sat_o));
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int last_in;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        o_res.delete(); o_sat.delete(); o_cyc.delete();
        o15_res.delete(); o15_sat.delete();
    endtask

    // Present one cycle of inputs; returns 1 time unit after the edge.
    task automatic drv(input int re, input int im, input bit v, input bit m, input bit c);
        bus16.real_i  = W_IN'(re);
        bus16.imag_i  = W_IN'(im);
        bus16.valid_i = v;
        bus16.mode_i  = m;
        bus16.clear_i = c;
        if (v) last_in = cyc_n;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit m);
        for (int i = 0; i < n; i++) drv(0, 0, 1'b0, m, 1'b0);
    endtask

    int exp_res[$];
    int exp_cyc[$];

    initial begin
        bus16.real_i = '0; bus16.imag_i = '0; bus16.valid_i = 1'b0;
        bus16.mode_i = 1'b0; bus16.clear_i = 1'b0;

        // Reset state
        rst = 1'b1;
        idle(3, 1'b0);
        chk("rst_res_o",   int'(bus16.res_o),   0);
        chk("rst_valid_o", int'(bus16.valid_o), 0);
        chk("rst_sat_o",   int'(bus16.sat_o),   0);
        chk("rst_valid15", int'(bus15.valid_o), 0);
        rst = 1'b0;
        idle(2, 1'b0);

        // Instantaneous: (3,4), (-128,-128), (127,127) back to back
        clear_logs();
        drv(3, 4, 1'b1, 1'b0, 1'b0);
        begin
            int t0;
            t0 = last_in;
            drv(-128, -128, 1'b1, 1'b0, 1'b0);
            drv(127, 127, 1'b1, 1'b0, 1'b0);
            idle(4, 1'b0);
            chk("inst_count", o_res.size(), 3);
            if (o_res.size() == 3) begin
                chk("inst_res0", o_res[0], 25);
                chk("inst_res1", o_res[1], 32768);
                chk("inst_res2", o_res[2], 32258);
                chk("inst_sat1", o_sat[1], 0);
                chk("inst_lat0", o_cyc[0] - t0, 2);
                chk("inst_lat1", o_cyc[1] - t0, 3);
            end
            chk("w15_count", o15_res.size(), 3);
            if (o15_res.size() == 3) begin
                chk("w15_res1", o15_res[1], 32767);
                chk("w15_sat1", o15_sat[1], 1);
                chk("w15_res2", o15_res[2], 32258);
                chk("w15_sat2", o15_sat[2], 0);
            end
        end

        // Random stream with bubbles, instantaneous mode
        clear_logs();
        exp_res.delete(); exp_cyc.delete();
        for (int i = 0; i < 20; i++) begin
            int re, im;
            if ($urandom_range(2, 0) == 0) idle(1, 1'b0);
            re = int'($urandom_range(255, 0)) - 128;
            im = int'($urandom_range(255, 0)) - 128;
            exp_res.push_back(re * re + im * im);
            exp_cyc.push_back(cyc_n + 2);
            drv(re, im, 1'b1, 1'b0, 1'b0);
        end
        idle(4, 1'b0);
        chk("stream_count", o_res.size(), 20);
        if (o_res.size() == 20) begin
            for (int i = 0; i < 20; i++) begin
                chk($sformatf("stream_res%0d", i), o_res[i], exp_res[i]);
                chk($sformatf("stream_cyc%0d", i), o_cyc[i], exp_cyc[i]);
            end
        end

        // Averaged: 16 x (3,4) with 5 bubbles
        clear_logs();
        for (int i = 0; i < 16; i++) begin
            drv(3, 4, 1'b1, 1'b1, 1'b0);
            if (i % 3 == 1 && i < 15) idle(1, 1'b1);
        end
        begin
            int t16;
            t16 = last_in;
            idle(5, 1'b1);
            chk("avg_count", o_res.size(), 1);
            if (o_res.size() == 1) begin
                chk("avg_res", o_res[0], 25);
                chk("avg_sat", o_sat[0], 0);
                chk("avg_lat", o_cyc[0] - t16, 3);
            end
        end

        // Averaged truncation: (1,0)/(0,0) x16 -> 8 >> 4 = 0
        clear_logs();
        for (int i = 0; i < 16; i++) drv(i % 2 == 0 ? 1 : 0, 0, 1'b1, 1'b1, 1'b0);
        idle(5, 1'b1);
        chk("trunc_count", o_res.size(), 1);
        if (o_res.size() == 1) chk("trunc_res", o_res[0], 0);

        // clear_i aligned with the 8th sample's sum
        clear_logs();
        for (int i = 0; i < 7; i++) drv(10, 0, 1'b1, 1'b1, 1'b0);
        drv(10, 0, 1'b1, 1'b1, 1'b0);
        drv(0, 0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) drv(0, 2, 1'b1, 1'b1, 1'b0);
        idle(5, 1'b1);
        chk("clr_count", o_res.size(), 1);
        if (o_res.size() == 1) chk("clr_res", o_res[0], 4);

        // Mode toggle 1 -> 0 -> 1 instead of clear
        clear_logs();
        for (int i = 0; i < 7; i++) drv(10, 0, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b1);
        drv(10, 0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        for (int i = 0; i < 16; i++) drv(0, 2, 1'b1, 1'b1, 1'b0);
        idle(5, 1'b1);
        chk("tog_count", o_res.size(), 2);
        if (o_res.size() == 2) begin
            chk("tog_inst", o_res[0], 100);
            chk("tog_avg",  o_res[1], 4);
        end

        // Reset mid-window
        clear_logs();
        for (int i = 0; i < 10; i++) drv(5, 5, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        drv(0, 0, 1'b0, 1'b1, 1'b0);
        chk("midrst_res",   int'(bus16.res_o),   0);
        chk("midrst_valid", int'(bus16.valid_o), 0);
        chk("midrst_sat",   int'(bus16.sat_o),   0);
        rst = 1'b0;
        idle(3, 1'b1);
        chk("midrst_nostrobe", o_res.size(), 0);
        for (int i = 0; i < 16; i++) drv(1, 1, 1'b1, 1'b1, 1'b0);
        idle(5, 1'b1);
        chk("postrst_count", o_res.size(), 1);
        if (o_res.size() == 1) chk("postrst_res", o_res[0], 2);
        chk("hold_res", int'(bus16.res_o), 2);
        chk("hold_valid", int'(bus16.valid_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
